unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter_pkg.sv | 19 +
 rtl/unified_mem_arbiter_if.sv | 28 ++
 rtl/unified_mem_arbiter_owner_fifo.sv | 55 +++++
 rtl/unified_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Owner IDs tag each granted transfer so responses can be routed back.
package ryuki_datatypes;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic owner_e other_owner(owner_e o);
    return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Shared memory bus bundle: req/gnt request phase plus in-order
// rvalid response phase.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/unified_mem_arbiter_owner_fifo.sv
// In-order FIFO of owner IDs for granted-but-unanswered transfers.
// Pointers wrap modulo DEPTH so non-power-of-two depths also work.
module owner_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_e push_id,
  input  logic   pop,
  output owner_e head_id,
  output logic   empty,
  output logic   full
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  owner_e        mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head_id = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter merging instruction and data ports onto one
// req/gnt/rvalid memory port, with in-order response routing.
module unified_mem_arbiter
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,
  output logic                    spurious_rvalid_o
);

  unified_mem_arbiter_if #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     rr_q, rr_d;
  owner_e     sel;
  owner_e     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       req;
  logic       gnt;
  logic       pop;
  logic       sel_d;

  assign bus.gnt    = mem_gnt_i;
  assign bus.rvalid = mem_rvalid_i;
  assign bus.rdata  = mem_rdata_i;
  assign bus.err    = mem_err_i;

  // A full FIFO blocks all requests, even if a pop frees a slot now.
  assign req = !rst_i && !fifo_full &&
               ((state_q == LOCKED) || instr_req_i || data_req_i);
  assign gnt = req && bus.gnt;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    sel     = owner_q;
    unique case (state_q)
      ARB: begin
        if (instr_req_i && data_req_i) sel = rr_q;
        else if (instr_req_i)          sel = OWN_INSTR;
        else                           sel = OWN_DATA;
        if (req && !bus.gnt) begin
          state_d = LOCKED;
          owner_d = sel;
        end
      end
      LOCKED: begin
        if (bus.gnt) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (gnt) rr_d = other_owner(sel);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      owner_q <= OWN_INSTR;
      rr_q    <= OWN_INSTR;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign sel_d = req && (sel == OWN_DATA);

  assign bus.req   = req;
  assign bus.addr  = !req ? '0 : (sel_d ? data_addr_i : instr_addr_i);
  assign bus.we    = sel_d && data_we_i;
  assign bus.be    = !req ? '0 : (sel_d ? data_be_i : '1);
  assign bus.wdata = sel_d ? data_wdata_i : '0;

  assign mem_req_o   = bus.req;
  assign mem_addr_o  = bus.addr;
  assign mem_we_o    = bus.we;
  assign mem_be_o    = bus.be;
  assign mem_wdata_o = bus.wdata;

  assign instr_gnt_o = gnt && (sel == OWN_INSTR);
  assign data_gnt_o  = gnt && (sel == OWN_DATA);

  owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk    (clk_i),
    .rst    (rst_i),
    .push   (gnt),
    .push_id(sel),
    .pop    (pop),
    .head_id(head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign pop               = !rst_i && bus.rvalid && !fifo_empty;
  assign spurious_rvalid_o = !rst_i && bus.rvalid && fifo_empty;

  // Responses bypass any register: route straight from the FIFO head.
  assign instr_rvalid_o = pop && (head == OWN_INSTR);
  assign data_rvalid_o  = pop && (head == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? bus.rdata : '0;
  assign data_rdata_o   = data_rvalid_o ? bus.rdata : '0;
  assign data_err_o     = data_rvalid_o && bus.err;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter; the bench plays the memory
// through the shared bus interface.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt, instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req, data_we;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        spurious;

  int vecs = 0;
  int errs = 0;

  unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  unified_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_req_i      (instr_req),
    .instr_addr_i     (instr_addr),
    .instr_gnt_o      (instr_gnt),
    .instr_rvalid_o   (instr_rvalid),
    .instr_rdata_o    (instr_rdata),
    .data_req_i       (data_req),
    .data_addr_i      (data_addr),
    .data_we_i        (data_we),
    .data_be_i        (data_be),
    .data_wdata_i     (data_wdata),
    .data_gnt_o       (data_gnt),
    .data_rvalid_o    (data_rvalid),
    .data_rdata_o     (data_rdata),
    .data_err_o       (data_err),
    .mem_req_o        (mem.req),
    .mem_addr_o       (mem.addr),
    .mem_we_o         (mem.we),
    .mem_be_o         (mem.be),
    .mem_wdata_o      (mem.wdata),
    .mem_gnt_i        (mem.gnt),
    .mem_rvalid_i     (mem.rvalid),
    .mem_rdata_i      (mem.rdata),
    .mem_err_i        (mem.err),
    .spurious_rvalid_o(spurious)
  );

  always #5 clk = ~clk;

  task automatic clr();
    instr_req  = 0; instr_addr = 32'h40;
    data_req   = 0; data_addr  = 32'h200;
    data_we    = 0; data_be    = 4'h3;
    data_wdata = 32'hDEAD_BEEF;
    mem.gnt    = 0; mem.rvalid = 0;
    mem.rdata  = 0; mem.err    = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    clr();
    rst = 1;
    instr_req = 1; data_req = 1;
    mem.gnt = 1; mem.rvalid = 1;
    mem.rdata = 32'h1234;
    cyc();
    #3;
    vecs++;
    if (mem.req !== 1'b0 || mem.addr !== 32'h0 || mem.be !== 4'h0
        || mem.wdata !== 32'h0 || mem.we !== 1'b0) begin
      errs++;
      $display("FAIL reset_mem req=%b addr=%h be=%h exp zeros",
               mem.req, mem.addr, mem.be);
    end
    vecs++;
    if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid,
         data_err, spurious} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b%b%b%b%b%b exp 000000",
               instr_gnt, data_gnt, instr_rvalid, data_rvalid,
               data_err, spurious);
    end
    vecs++;
    if (instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errs++;
      $display("FAIL reset_rdata got %h/%h exp 0",
               instr_rdata, data_rdata);
    end
    clr();
    cyc();
    rst = 0;
  endtask

  task automatic test_single_instr();
    cyc();
    instr_req = 1; instr_addr = 32'h20; mem.gnt = 1;
    #3;
    vecs++;
    if (instr_gnt !== 1'b1 || data_gnt !== 1'b0) begin
      errs++;
      $display("FAIL single_gnt got i=%b d=%b exp i=1 d=0",
               instr_gnt, data_gnt);
    end
    vecs++;
    if (mem.req !== 1'b1 || mem.addr !== 32'h20
        || mem.we !== 1'b0 || mem.be !== 4'hF) begin
      errs++;
      $display("FAIL single_bus req=%b addr=%h we=%b be=%h exp 1/20/0/f",
               mem.req, mem.addr, mem.we, mem.be);
    end
    cyc();
    instr_req = 0; mem.gnt = 0;
    mem.rvalid = 1; mem.rdata = 32'h0000_0013;
    #3;
    vecs++;
    if (instr_rvalid !== 1'b1 || instr_rdata !== 32'h13
        || data_rvalid !== 1'b0 || data_gnt !== 1'b0) begin
      errs++;
      $display("FAIL single_rsp rv=%b rdata=%h drv=%b exp 1/13/0",
               instr_rvalid, instr_rdata, data_rvalid);
    end
    vecs++;
    if (spurious !== 1'b0) begin
      errs++;
      $display("FAIL single_spur got %b exp 0", spurious);
    end
    cyc();
    clr();
  endtask

  task automatic test_round_robin();
    logic eig, edg, eirv, edrv;
    logic [31:0] eaddr;
    do_reset();
    data_we = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      instr_req  = (i < 4);
      data_req   = (i < 4);
      mem.gnt    = (i < 4);
      mem.rvalid = (i > 0);
      mem.rdata  = 32'hA0 + i;
      #3;
      eig   = (i < 4) && (i % 2 == 0);
      edg   = (i < 4) && (i % 2 == 1);
      eirv  = (i > 0) && ((i - 1) % 2 == 0);
      edrv  = (i > 0) && ((i - 1) % 2 == 1);
      eaddr = (i >= 4) ? 32'h0 : (edg ? 32'h200 : 32'h40);
      vecs++;
      if (instr_gnt !== eig || data_gnt !== edg) begin
        errs++;
        $display("FAIL rr_gnt[%0d] got i=%b d=%b exp i=%b d=%b",
                 i, instr_gnt, data_gnt, eig, edg);
      end
      vecs++;
      if (mem.addr !== eaddr || mem.we !== edg
          || mem.be !== (edg ? 4'h3 : (eig ? 4'hF : 4'h0))) begin
        errs++;
        $display("FAIL rr_bus[%0d] addr=%h we=%b be=%h exp addr=%h",
                 i, mem.addr, mem.we, mem.be, eaddr);
      end
      vecs++;
      if (instr_rvalid !== eirv || data_rvalid !== edrv
          || (eirv && instr_rdata !== 32'hA0 + i)
          || (edrv && data_rdata !== 32'hA0 + i)) begin
        errs++;
        $display("FAIL rr_rsp[%0d] got i=%b d=%b exp i=%b d=%b",
                 i, instr_rvalid, data_rvalid, eirv, edrv);
      end
    end
    cyc();
    clr();
  endtask

  task automatic test_locked();
    data_req = 1; data_addr = 32'h100;
    #3;
    vecs++;
    if (mem.req !== 1'b1 || mem.addr !== 32'h100 || data_gnt !== 1'b0) begin
      errs++;
      $display("FAIL lock_start req=%b addr=%h gnt=%b exp 1/100/0",
               mem.req, mem.addr, data_gnt);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      instr_req = 1;
      #3;
      vecs++;
      if (mem.addr !== 32'h100 || instr_gnt !== 1'b0
          || data_gnt !== 1'b0) begin
        errs++;
        $display("FAIL lock_hold[%0d] addr=%h ig=%b dg=%b exp 100/0/0",
                 i, mem.addr, instr_gnt, data_gnt);
      end
    end
    cyc();
    mem.gnt = 1;
    #3;
    vecs++;
    if (mem.addr !== 32'h100 || data_gnt !== 1'b1 || instr_gnt !== 1'b0) begin
      errs++;
      $display("FAIL lock_gnt addr=%h dg=%b ig=%b exp 100/1/0",
               mem.addr, data_gnt, instr_gnt);
    end
    cyc();
    data_req = 0;
    mem.rvalid = 1; mem.err = 1; mem.rdata = 32'h77;
    #3;
    vecs++;
    if (instr_gnt !== 1'b1 || mem.addr !== 32'h40) begin
      errs++;
      $display("FAIL lock_next ig=%b addr=%h exp 1/40",
               instr_gnt, mem.addr);
    end
    vecs++;
    if (data_rvalid !== 1'b1 || data_err !== 1'b1
        || data_rdata !== 32'h77) begin
      errs++;
      $display("FAIL lock_derr rv=%b err=%b rdata=%h exp 1/1/77",
               data_rvalid, data_err, data_rdata);
    end
    cyc();
    instr_req = 0; mem.gnt = 0; mem.rdata = 32'h55;
    #3;
    vecs++;
    if (instr_rvalid !== 1'b1 || instr_rdata !== 32'h55
        || data_err !== 1'b0 || data_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL lock_ierr rv=%b rdata=%h derr=%b exp 1/55/0",
               instr_rvalid, instr_rdata, data_err);
    end
    cyc();
    clr();
  endtask

  task automatic test_full();
    instr_req = 1; mem.gnt = 1;
    for (int i = 0; i < 2; i++) begin
      #3;
      vecs++;
      if (instr_gnt !== 1'b1) begin
        errs++;
        $display("FAIL full_fill[%0d] got %b exp 1", i, instr_gnt);
      end
      cyc();
    end
    #3;
    vecs++;
    if (mem.req !== 1'b0 || instr_gnt !== 1'b0) begin
      errs++;
      $display("FAIL full_block req=%b gnt=%b exp 0/0", mem.req, instr_gnt);
    end
    cyc();
    mem.rvalid = 1;
    #3;
    vecs++;
    if (mem.req !== 1'b0 || instr_gnt !== 1'b0 || instr_rvalid !== 1'b1) begin
      errs++;
      $display("FAIL full_pop req=%b gnt=%b rv=%b exp 0/0/1",
               mem.req, instr_gnt, instr_rvalid);
    end
    cyc();
    #3;
    vecs++;
    if (mem.req !== 1'b1 || instr_gnt !== 1'b1 || instr_rvalid !== 1'b1) begin
      errs++;
      $display("FAIL full_reopen req=%b gnt=%b rv=%b exp 1/1/1",
               mem.req, instr_gnt, instr_rvalid);
    end
    cyc();
    instr_req = 0; mem.gnt = 0;
    #3;
    vecs++;
    if (instr_rvalid !== 1'b1 || spurious !== 1'b0) begin
      errs++;
      $display("FAIL full_drain rv=%b spur=%b exp 1/0",
               instr_rvalid, spurious);
    end
    cyc();
    clr();
  endtask

  task automatic test_spurious();
    mem.rvalid = 1;
    #3;
    vecs++;
    if (spurious !== 1'b1 || instr_rvalid !== 1'b0
        || data_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL spur_empty spur=%b irv=%b drv=%b exp 1/0/0",
               spurious, instr_rvalid, data_rvalid);
    end
    cyc();
    mem.rvalid = 0;
    #3;
    vecs++;
    if (spurious !== 1'b0) begin
      errs++;
      $display("FAIL spur_pulse got %b exp 0", spurious);
    end
    cyc();
    data_req = 1; mem.gnt = 1;
    #3;
    vecs++;
    if (data_gnt !== 1'b1) begin
      errs++;
      $display("FAIL spur_grant got %b exp 1", data_gnt);
    end
    cyc();
    clr();
    rst = 1; mem.rvalid = 1;
    #3;
    vecs++;
    if (spurious !== 1'b0 || data_rvalid !== 1'b0 || mem.req !== 1'b0) begin
      errs++;
      $display("FAIL spur_inrst spur=%b drv=%b req=%b exp 0/0/0",
               spurious, data_rvalid, mem.req);
    end
    cyc();
    rst = 0; mem.rvalid = 0;
    cyc();
    mem.rvalid = 1;
    #3;
    vecs++;
    if (spurious !== 1'b1 || data_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL spur_postrst spur=%b drv=%b exp 1/0",
               spurious, data_rvalid);
    end
    cyc();
    clr();
  endtask

  initial begin
    test_reset();
    test_single_instr();
    test_round_robin();
    test_locked();
    test_full();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
